packet_scheduler: RTL
=====================

# packet_scheduler

Packet-level crossbar scheduler for the 3-port switch. Watches the head word of each input FIFO, which is show-ahead with the head on `dataN` whenever `emptyN` is low. Grants each output port to one input for a whole packet using per-output round-robin, and drives the crossbar selects/enables and FIFO read requests. It replaces per-word fixed-priority scheduling, so packets never interleave on an output and no input starves.

## Interface
Parameters:
- none. The block is fixed at 3 ports and 8-bit words. Header fields: `[1:0]` dest (`01`/`10`/`11` = output 1/2/3, `00` = discard), `[7:2]` payload length L (0..63 words after the header).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `data1`, `data2`, `data3` in 8: head word of input FIFO N.
- `empty1`, `empty2`, `empty3` in 1: FIFO N empty.
- `sel1`, `sel2`, `sel3` out 2: input feeding output N (`01`/`10`/`11`), `00` = none.
- `en1`, `en2`, `en3` out 1: output N carries a valid word this cycle.
- `rdreq1`, `rdreq2`, `rdreq3` out 1: pop FIFO N at next edge.

## Operation
- Per-input state: IDLE (head is a header), FWD(out), DROP. Each input also has a 6-bit remaining count `rem`.
- An output is busy when some input is in FWD to it (registered state).
- **Grant (input IDLE, not empty, dest≠00):**
  - Candidate for output `dest` if that output is not busy.
  - Each output picks one candidate with a 3-way round-robin starting after its last-granted input.
  - The winner pops its header (`rdreq`=1), and the output gets `en`=1 with `sel`=winner.
  - Losers: `rdreq`=0, they retry next cycle.
- On grant: if L=0, the input stays IDLE. Otherwise the input goes to FWD(dest) with `rem`=L. The output's round-robin pointer becomes the winner.
- **FWD, not empty:** pop, `en`/`sel` driven for the owned output, `rem`−1. When `rem`=1, return to IDLE.
- **FWD, empty:** stall. `rdreq`=0, `en`=0, `sel` holds the owner, ownership is kept.
- **IDLE, dest=00, not empty:** pop header with no `en`. If L>0, go to DROP with `rem`=L. DROP pops one word per non-empty cycle with no `en`, and returns to IDLE at the last word.
- No two inputs ever drive the same output in one cycle. Each input drives at most one output.
- Round-robin pointers after reset: last-granted = input 3, so input 1 has first priority.

## Timing
- `sel*`, `en*`, `rdreq*` are combinational from registered state plus the current `data*`/`empty*`. This gives zero-cycle latency: a header is forwarded in the cycle it is granted.
- `rdreq` is never asserted while the corresponding `empty` is high.
- **Multi-word packets:** the output is busy from the cycle after the header through the last-payload cycle. The earliest new grant on that output is the cycle after the last payload word.
- **Single-word packets (L=0):** never set busy. A port can accept a different input's single-word packet every cycle.
- **Reset:**
  - While `reset`=1, all outputs are 0.
  - At the edge, all inputs go to IDLE, `rem`=0, and pointers return to their reset value.
  - Reset mid-packet abandons the packet. Remaining words are later read as headers; upstream flushing is out of scope.
- A pop in the same cycle as an upstream write is the FIFO's concern. The scheduler only samples `empty`.

## Structure
- Package `switch_pkg`:
  - port code constants `PORT_NONE`/`PORT1..3`;
  - header field ranges `DEST_LSB/MSB`, `LEN_LSB/MSB`;
  - input state enum `in_state_t` {IDLE, FWD, DROP}.
- Sub-module `rr_arb3`:
  - 3-bit request vector plus 2-bit last-grant pointer in, one-hot grant out;
  - combinational;
  - instantiated once per output.
- Per-input state/counter logic and the output drive live in `packet_scheduler`.

## Test plan
- **Reset:** hold `reset` 2 cycles with all FIFOs non-empty → all `sel`=00, `en`=0, `rdreq`=0. First cycle after release with `data1`=8'h02 → `rdreq1`=1, `en2`=1, `sel2`=01.
- **Contention:** `data1`=`data3`=8'h03 (L=0, dest 3), both non-empty, pointer at reset → cycle 0 grants input 1 (`sel3`=01, `rdreq3`=0), cycle 1 grants input 3 (`sel3`=11).
- **Multi-word with stall:**
  - `data2`=8'h0D (L=3, dest 1) → `en1`=1, `sel1`=10 for 4 popped words.
  - `empty2` high for 2 cycles mid-packet → `en1`=0, `rdreq2`=0, `sel1` stays 10.
  - A concurrent `data3`=8'h01 is not granted until the cycle after the last word.
- **Drop:** `data1`=8'h08 (L=2, dest 0) → `rdreq1`=1 for 3 cycles, all `en`=0.
- **Fairness:** inputs 1 and 2 continuously send L=1 packets to output 2 → grants alternate 01,10,01,… per packet, never interleaving words.
- **Reset mid-packet:** assert `reset` during word 2 of an L=5 packet → outputs 0 that cycle, and port 1 is free to grant a new header the cycle after release.

Source files
------------

// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - port codes, header field ranges and per-input state for the 3-port switch
package switch_pkg;

    localparam logic [1:0] PORT_NONE = 2'b00;
    localparam logic [1:0] PORT1     = 2'b01;
    localparam logic [1:0] PORT2     = 2'b10;
    localparam logic [1:0] PORT3     = 2'b11;

    localparam int DEST_LSB = 0;
    localparam int DEST_MSB = 1;
    localparam int LEN_LSB  = 2;
    localparam int LEN_MSB  = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } in_state_t;

    // Zero-based port index to its 2-bit port code.
    function automatic logic [1:0] port_code(input int idx);
        return 2'(idx + 1);
    endfunction

endpackage

// File: rtl/packet_scheduler_if.sv
// rtl/packet_scheduler_if.sv - FIFO head/empty inputs and crossbar/pop outputs of the scheduler
interface packet_scheduler_if;
    logic [7:0] data1, data2, data3;
    logic       empty1, empty2, empty3;
    logic [1:0] sel1, sel2, sel3;
    logic       en1, en2, en3;
    logic       rdreq1, rdreq2, rdreq3;

    modport master (
        input  data1, data2, data3, empty1, empty2, empty3,
        output sel1, sel2, sel3, en1, en2, en3, rdreq1, rdreq2, rdreq3
    );

    modport slave (
        output data1, data2, data3, empty1, empty2, empty3,
        input  sel1, sel2, sel3, en1, en2, en3, rdreq1, rdreq2, rdreq3
    );
endinterface

// File: rtl/rr_arb3.sv
// rtl/rr_arb3.sv - 3-way round-robin picker, search starts at the input after the last grant
module rr_arb3 (
    input  logic [2:0] i_req,
    input  logic [1:0] i_last,
    output logic [2:0] o_gnt
);

    always_comb begin
        o_gnt = 3'b000;
        case (i_last)
            2'b01: begin
                if      (i_req[1]) o_gnt = 3'b010;
                else if (i_req[2]) o_gnt = 3'b100;
                else if (i_req[0]) o_gnt = 3'b001;
            end
            2'b10: begin
                if      (i_req[2]) o_gnt = 3'b100;
                else if (i_req[0]) o_gnt = 3'b001;
                else if (i_req[1]) o_gnt = 3'b010;
            end
            default: begin
                if      (i_req[0]) o_gnt = 3'b001;
                else if (i_req[1]) o_gnt = 3'b010;
                else if (i_req[2]) o_gnt = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/packet_scheduler.sv
// rtl/packet_scheduler.sv - packet-granular crossbar scheduler with per-output round-robin
module packet_scheduler
    import switch_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    packet_scheduler_if.master  io_bus
);

    logic [7:0] w_data  [3];
    logic [2:0] w_empty;

    in_state_t  r_state [3];
    in_state_t  w_state_nx [3];
    logic [1:0] r_out   [3];
    logic [1:0] w_out_nx [3];
    logic [5:0] r_rem   [3];
    logic [5:0] w_rem_nx [3];
    logic [1:0] r_last  [3];
    logic [1:0] w_last_nx [3];

    logic [2:0] w_busy;
    logic [1:0] w_owner [3];
    logic [2:0] w_req   [3];
    logic [2:0] w_gnt   [3];

    logic [1:0] w_sel   [3];
    logic [2:0] w_en;
    logic [2:0] w_rdreq;

    assign w_data[0] = io_bus.data1;
    assign w_data[1] = io_bus.data2;
    assign w_data[2] = io_bus.data3;
    assign w_empty   = {io_bus.empty3, io_bus.empty2, io_bus.empty1};

    // An output is owned only from the cycle after its header until the last payload word.
    always_comb begin
        for (int o = 0; o < 3; o++) begin
            w_busy[o]  = 1'b0;
            w_owner[o] = 2'd0;
            for (int i = 0; i < 3; i++) begin
                if (r_state[i] == FWD && r_out[i] == port_code(o)) begin
                    w_busy[o]  = 1'b1;
                    w_owner[o] = 2'(i);
                end
            end
        end
    end

    always_comb begin
        for (int o = 0; o < 3; o++) begin
            for (int i = 0; i < 3; i++) begin
                w_req[o][i] = (r_state[i] == IDLE) && !w_empty[i] && !w_busy[o] &&
                              (w_data[i][DEST_MSB:DEST_LSB] == port_code(o));
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_arb
        rr_arb3 u_arb (
            .i_req  (w_req[g]),
            .i_last (r_last[g]),
            .o_gnt  (w_gnt[g])
        );
    end

    always_comb begin
        w_en    = 3'b000;
        w_rdreq = 3'b000;
        for (int o = 0; o < 3; o++) begin
            w_sel[o]     = PORT_NONE;
            w_last_nx[o] = r_last[o];
        end
        for (int i = 0; i < 3; i++) begin
            w_state_nx[i] = r_state[i];
            w_out_nx[i]   = r_out[i];
            w_rem_nx[i]   = r_rem[i];
        end

        for (int o = 0; o < 3; o++) begin
            if (w_busy[o]) begin
                w_sel[o] = port_code(int'(w_owner[o]));
                w_en[o]  = !w_empty[w_owner[o]];
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (w_gnt[o][i]) begin
                        w_sel[o]     = port_code(i);
                        w_en[o]      = 1'b1;
                        w_rdreq[i]   = 1'b1;
                        w_last_nx[o] = port_code(i);
                        if (w_data[i][LEN_MSB:LEN_LSB] != 6'd0) begin
                            w_state_nx[i] = FWD;
                            w_out_nx[i]   = port_code(o);
                            w_rem_nx[i]   = w_data[i][LEN_MSB:LEN_LSB];
                        end
                    end
                end
            end
        end

        for (int i = 0; i < 3; i++) begin
            case (r_state[i])
                IDLE: begin
                    if (!w_empty[i] && w_data[i][DEST_MSB:DEST_LSB] == PORT_NONE) begin
                        w_rdreq[i] = 1'b1;
                        if (w_data[i][LEN_MSB:LEN_LSB] != 6'd0) begin
                            w_state_nx[i] = DROP;
                            w_rem_nx[i]   = w_data[i][LEN_MSB:LEN_LSB];
                        end
                    end
                end
                FWD, DROP: begin
                    if (!w_empty[i]) begin
                        w_rdreq[i]  = 1'b1;
                        w_rem_nx[i] = r_rem[i] - 6'd1;
                        if (r_rem[i] == 6'd1) w_state_nx[i] = IDLE;
                    end
                end
                default: w_state_nx[i] = IDLE;
            endcase
        end

        if (reset) begin
            w_en    = 3'b000;
            w_rdreq = 3'b000;
            for (int o = 0; o < 3; o++) w_sel[o] = PORT_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                r_state[i] <= IDLE;
                r_out[i]   <= PORT_NONE;
                r_rem[i]   <= 6'd0;
                r_last[i]  <= PORT3;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_state[i] <= w_state_nx[i];
                r_out[i]   <= w_out_nx[i];
                r_rem[i]   <= w_rem_nx[i];
                r_last[i]  <= w_last_nx[i];
            end
        end
    end

    assign io_bus.sel1   = w_sel[0];
    assign io_bus.sel2   = w_sel[1];
    assign io_bus.sel3   = w_sel[2];
    assign io_bus.en1    = w_en[0];
    assign io_bus.en2    = w_en[1];
    assign io_bus.en3    = w_en[2];
    assign io_bus.rdreq1 = w_rdreq[0];
    assign io_bus.rdreq2 = w_rdreq[1];
    assign io_bus.rdreq3 = w_rdreq[2];

endmodule
